// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch-stage lookup and memory-stage training signals
// shared between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(
    parameter int HIST_W = 6
);
    logic [31:0]       PCF;
    logic              PredTakenF;
    logic [31:0]       PredTargetF;
    logic [HIST_W-1:0] GhrF;
    logic              UpdateEnM;
    logic              IsJumpM;
    logic [31:0]       UpdatePCM;
    logic              TakenM;
    logic [31:0]       TargetM;
    logic              PredTakenM;
    logic [31:0]       PredTargetM;
    logic [HIST_W-1:0] GhrM;
    logic              MispredictM;
    logic [31:0]       RedirectPCM;
    logic [31:0]       PerfBranches;
    logic [31:0]       PerfMispredicts;

    modport master (
        output PCF, UpdateEnM, IsJumpM, UpdatePCM, TakenM, TargetM, PredTakenM, PredTargetM, GhrM,
        input  PredTakenF, PredTargetF, GhrF, MispredictM, RedirectPCM, PerfBranches, PerfMispredicts
    );

    modport slave (
        input  PCF, UpdateEnM, IsJumpM, UpdatePCM, TakenM, TargetM, PredTakenM, PredTargetM, GhrM,
        output PredTakenF, PredTargetF, GhrF, MispredictM, RedirectPCM, PerfBranches, PerfMispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: BTB plus 2-bit PHT with bimodal or gshare indexing; zero-latency
// fetch lookup, memory-stage training, mispredict detection and perf counters.
module branch_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int MODE    = 0,
    parameter int HIST_W  = $clog2(ENTRIES)
) (
    input logic               CLK,
    input logic               RESETn,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         pht_q [ENTRIES];
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [31:0]        br_q, br_d, mp_q, mp_d;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic               jump_q [ENTRIES];
    logic [IDX_W-1:0]   bidx_f, bidx_m, pidx_m;
    logic [1:0]         pht_m, pht_d;
    logic               hit_f, upd_cond, upd_btb, unused_ok;

    function automatic logic [IDX_W-1:0] pidx(input logic [31:0] pc, input logic [HIST_W-1:0] h);
        return MODE == 1 ? pc[IDX_W+1:2] ^ IDX_W'(h) : pc[IDX_W+1:2];
    endfunction

    assign bidx_f         = bp.PCF[IDX_W+1:2];
    assign hit_f          = valid_q[bidx_f] && tag_q[bidx_f] == bp.PCF[IDX_W+2 +: TAG_W];
    assign bp.PredTakenF  = hit_f && (jump_q[bidx_f] || pht_q[pidx(bp.PCF, ghr_q)][1]);
    assign bp.PredTargetF = bp.PredTakenF ? target_q[bidx_f] : bp.PCF + 32'd4;
    assign bp.GhrF        = ghr_q;

    assign bp.MispredictM = bp.UpdateEnM &&
                            (bp.PredTakenM != bp.TakenM || (bp.TakenM && bp.PredTargetM != bp.TargetM));
    assign bp.RedirectPCM     = bp.TakenM ? bp.TargetM : bp.UpdatePCM + 32'd4;
    assign bp.PerfBranches    = br_q;
    assign bp.PerfMispredicts = mp_q;

    // Training uses the history captured at lookup (GhrM), not the live GHR.
    assign bidx_m   = bp.UpdatePCM[IDX_W+1:2];
    assign pidx_m   = pidx(bp.UpdatePCM, bp.GhrM);
    assign upd_cond = bp.UpdateEnM && !bp.IsJumpM;
    assign upd_btb  = bp.UpdateEnM && bp.TakenM;
    assign pht_m    = pht_q[pidx_m];
    assign unused_ok = ^{bp.PCF, bp.UpdatePCM, bp.GhrM};

    always_comb begin
        valid_d = valid_q;
        if (upd_btb) valid_d[bidx_m] = 1'b1;
        pht_d = !upd_cond ? pht_m
              : bp.TakenM ? (&pht_m ? pht_m : pht_m + 2'd1)
              : (|pht_m ? pht_m - 2'd1 : pht_m);
        ghr_d = upd_cond ? HIST_W'({ghr_q, bp.TakenM}) : ghr_q;
        br_d  = br_q + 32'(bp.UpdateEnM);
        mp_d  = mp_q + 32'(bp.MispredictM);
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
            ghr_q <= '0;
            br_q  <= '0;
            mp_q  <= '0;
        end else begin
            valid_q       <= valid_d;
            pht_q[pidx_m] <= pht_d;
            ghr_q         <= ghr_d;
            br_q          <= br_d;
            mp_q          <= mp_d;
        end
    end

    // Payload arrays are qualified by valid, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (upd_btb) begin
            tag_q[bidx_m]    <= bp.UpdatePCM[IDX_W+2 +: TAG_W];
            target_q[bidx_m] <= bp.TargetM;
            jump_q[bidx_m]   <= bp.IsJumpM;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: bimodal and gshare predictors driven in lockstep and checked
// against a table-level reference model of the BTB, PHT, history and counters.
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] pcf, upc, tgt, ptgt;
    logic        en, jmp, tk, ptk;
    logic [5:0]  ghrm;

    branch_predictor_if #(.HIST_W(6)) b0 ();
    branch_predictor_if #(.HIST_W(6)) b1 ();

    branch_predictor #(.ENTRIES(64), .TAG_W(8), .MODE(0), .HIST_W(6)) dut0 (.CLK(clk), .RESETn(rst_n), .bp(b0));
    branch_predictor #(.ENTRIES(64), .TAG_W(8), .MODE(1), .HIST_W(6)) dut1 (.CLK(clk), .RESETn(rst_n), .bp(b1));

    assign b0.PCF = pcf;         assign b1.PCF = pcf;
    assign b0.UpdateEnM = en;    assign b1.UpdateEnM = en;
    assign b0.IsJumpM = jmp;     assign b1.IsJumpM = jmp;
    assign b0.UpdatePCM = upc;   assign b1.UpdatePCM = upc;
    assign b0.TakenM = tk;       assign b1.TakenM = tk;
    assign b0.TargetM = tgt;     assign b1.TargetM = tgt;
    assign b0.PredTakenM = ptk;  assign b1.PredTakenM = ptk;
    assign b0.PredTargetM = ptgt; assign b1.PredTargetM = ptgt;
    assign b0.GhrM = ghrm;       assign b1.GhrM = ghrm;

    bit          m_valid [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    bit          m_jmp [64];
    int          m_pht [2][64];
    int          m_ghr;
    logic [31:0] m_br, m_mp;
    int          pass_n = 0, total_n = 0;

    logic        o_pt [2];
    logic [31:0] o_tg [2];
    logic [5:0]  o_gh [2];
    logic        o_mp [2];
    logic [31:0] o_rd [2], o_pb [2], o_pm [2];

    function automatic int pidx(int mode, logic [31:0] pc, int h);
        int unsigned p;
        p = pc / 4;
        if (mode == 1) p = p ^ 32'(h);
        return int'(p % 64);
    endfunction

    function automatic bit exp_taken(int mode, logic [31:0] pc);
        int unsigned b;
        b = (pc / 4) % 64;
        return m_valid[b] && m_tag[b] == (pc / 256) % 256 && (m_jmp[b] || m_pht[mode][pidx(mode, pc, m_ghr)] >= 2);
    endfunction

    function automatic logic [31:0] exp_target(int mode, logic [31:0] pc);
        return exp_taken(mode, pc) ? m_tgt[(pc / 4) % 64] : pc + 32'd4;
    endfunction

    function automatic bit exp_misp();
        return en && (ptk != tk || (tk && ptgt != tgt));
    endfunction

    function automatic logic [31:0] exp_redir();
        return tk ? tgt : upc + 32'd4;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_pht[0][i] = 1;
            m_pht[1][i] = 1;
        end
        m_ghr = 0;
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void model_update();
        int unsigned b;
        b = (upc / 4) % 64;
        if (!en) return;
        m_br++;
        if (exp_misp()) m_mp++;
        if (!jmp) begin
            for (int m = 0; m < 2; m++) begin
                int i;
                i = pidx(m, upc, int'(ghrm));
                m_pht[m][i] = tk ? (m_pht[m][i] < 3 ? m_pht[m][i] + 1 : 3) : (m_pht[m][i] > 0 ? m_pht[m][i] - 1 : 0);
            end
            m_ghr = (m_ghr * 2 + int'(tk)) % 64;
        end
        if (tk) begin
            m_valid[b] = 1;
            m_tag[b]   = (upc / 256) % 256;
            m_tgt[b]   = tgt;
            m_jmp[b]   = jmp;
        end
    endfunction

    task automatic snap();
        o_pt[0] = b0.PredTakenF;      o_pt[1] = b1.PredTakenF;
        o_tg[0] = b0.PredTargetF;     o_tg[1] = b1.PredTargetF;
        o_gh[0] = b0.GhrF;            o_gh[1] = b1.GhrF;
        o_mp[0] = b0.MispredictM;     o_mp[1] = b1.MispredictM;
        o_rd[0] = b0.RedirectPCM;     o_rd[1] = b1.RedirectPCM;
        o_pb[0] = b0.PerfBranches;    o_pb[1] = b1.PerfBranches;
        o_pm[0] = b0.PerfMispredicts; o_pm[1] = b1.PerfMispredicts;
    endtask

    task automatic idle();
        en = 0; jmp = 0; upc = 0; tk = 0; tgt = 0; ptk = 0; ptgt = 0; ghrm = 6'(m_ghr);
    endtask

    task automatic drive(input logic e, input logic j, input logic [31:0] u, input logic t,
                         input logic [31:0] g, input logic p, input logic [31:0] pg);
        en = e; jmp = j; upc = u; tk = t; tgt = g; ptk = p; ptgt = pg; ghrm = 6'(m_ghr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_pc();
        return 32'h00400000 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 1)) * 256;
    endfunction

    task automatic test_reset();
        idle();
        pcf = 32'h00400000;
        #2 rst_n = 0;
        model_reset();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b0) $display("FAIL reset_pred dut%0d got %h want 0", d, o_pt[d]); else pass_n++;
            total_n++; if (o_tg[d] !== 32'h00400004) $display("FAIL reset_target dut%0d got %h want 00400004", d, o_tg[d]); else pass_n++;
            total_n++; if (o_gh[d] !== 6'd0) $display("FAIL reset_ghr dut%0d got %h want 0", d, o_gh[d]); else pass_n++;
            total_n++; if (o_mp[d] !== 1'b0) $display("FAIL reset_misp dut%0d got %h want 0", d, o_mp[d]); else pass_n++;
            total_n++; if (o_pb[d] !== 32'd0 || o_pm[d] !== 32'd0) $display("FAIL reset_perf dut%0d got %h/%h want 0/0", d, o_pb[d], o_pm[d]); else pass_n++;
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_bimodal();
        bit outc [5] = '{1, 1, 1, 0, 0};
        bit exp0 [5] = '{1, 1, 1, 1, 0};
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h00400010, outc[i], 32'h00400000, 0, 32'h00400014);
            pcf = 32'h00400010;
            tick();
            idle();
            #1 snap();
            total_n++; if (o_pt[0] !== exp0[i]) $display("FAIL bimodal_pred step%0d got %h want %h", i, o_pt[0], exp0[i]); else pass_n++;
            total_n++; if (o_tg[0] !== (exp0[i] ? 32'h00400000 : 32'h00400014)) $display("FAIL bimodal_target step%0d got %h want %h", i, o_tg[0], exp0[i] ? 32'h00400000 : 32'h00400014); else pass_n++;
            total_n++; if (o_pt[1] !== exp_taken(1, pcf)) $display("FAIL gshare_train_pred step%0d got %h want %h", i, o_pt[1], exp_taken(1, pcf)); else pass_n++;
        end
    endtask

    task automatic test_alias();
        pcf = 32'h00400110;
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b0) $display("FAIL alias_pred dut%0d got %h want 0", d, o_pt[d]); else pass_n++;
            total_n++; if (o_tg[d] !== 32'h00400114) $display("FAIL alias_target dut%0d got %h want 00400114", d, o_tg[d]); else pass_n++;
        end
    endtask

    task automatic test_jump_mispredict();
        logic [31:0] eb, em;
        drive(1, 1, 32'h00400020, 1, 32'h00400100, 0, 32'h00400024);
        pcf = 32'h00400020;
        tick();
        idle();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b1) $display("FAIL jump_pred dut%0d got %h want 1", d, o_pt[d]); else pass_n++;
            total_n++; if (o_tg[d] !== 32'h00400100) $display("FAIL jump_target dut%0d got %h want 00400100", d, o_tg[d]); else pass_n++;
        end
        drive(1, 1, 32'h00400020, 1, 32'h00400008, 1, 32'h00400000);
        eb = m_br + 1;
        em = m_mp + 1;
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_mp[d] !== 1'b1) $display("FAIL target_misp dut%0d got %h want 1", d, o_mp[d]); else pass_n++;
            total_n++; if (o_rd[d] !== 32'h00400008) $display("FAIL target_redirect dut%0d got %h want 00400008", d, o_rd[d]); else pass_n++;
        end
        tick();
        idle();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pb[d] !== eb) $display("FAIL perf_branches dut%0d got %h want %h", d, o_pb[d], eb); else pass_n++;
            total_n++; if (o_pm[d] !== em) $display("FAIL perf_mispredicts dut%0d got %h want %h", d, o_pm[d], em); else pass_n++;
        end
        drive(1, 0, 32'h00400060, 0, 32'h00400000, 0, 32'h00400000);
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_mp[d] !== 1'b0) $display("FAIL correct_nt_misp dut%0d got %h want 0", d, o_mp[d]); else pass_n++;
            total_n++; if (o_rd[d] !== 32'h00400064) $display("FAIL nt_redirect dut%0d got %h want 00400064", d, o_rd[d]); else pass_n++;
        end
        en = 0; ptk = 1; tk = 0;
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_mp[d] !== 1'b0) $display("FAIL disabled_misp dut%0d got %h want 0", d, o_mp[d]); else pass_n++;
        end
        idle();
    endtask

    task automatic test_gshare();
        bit seq [3] = '{1, 1, 0};
        rst_n = 0;
        model_reset();
        #1 @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h00400040, seq[i], 32'h00400200, 0, 32'h00400044);
            tick();
        end
        drive(1, 1, 32'h00400050, 1, 32'h00400300, 1, 32'h00400300);
        tick();
        idle();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_gh[d] !== 6'b000110) $display("FAIL ghr_history dut%0d got %b want 000110", d, o_gh[d]); else pass_n++;
        end
        drive(1, 0, 32'h00400080, 1, 32'h00400400, 0, 32'h00400084);
        tick();
        idle();
        pcf = 32'h00400080;
        #1 snap();
        total_n++; if (o_pt[0] !== 1'b1) $display("FAIL bimodal_index_pred got %h want 1", o_pt[0]); else pass_n++;
        total_n++; if (o_pt[1] !== 1'b0) $display("FAIL gshare_index_pred got %h want 0", o_pt[1]); else pass_n++;
        total_n++; if (o_gh[1] !== 6'b001101) $display("FAIL gshare_ghr got %b want 001101", o_gh[1]); else pass_n++;
    endtask

    task automatic test_collision();
        rst_n = 0;
        model_reset();
        #1 @(negedge clk);
        rst_n = 1;
        pcf = 32'h00400030;
        drive(1, 0, 32'h00400030, 1, 32'h00400200, 0, 32'h00400034);
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b0) $display("FAIL collide_same_cycle dut%0d got %h want 0", d, o_pt[d]); else pass_n++;
        end
        tick();
        idle();
        #1 snap();
        total_n++; if (o_pt[0] !== 1'b1 || o_tg[0] !== 32'h00400200) $display("FAIL collide_next_cycle got %h/%h want 1/00400200", o_pt[0], o_tg[0]); else pass_n++;
        total_n++; if (o_pt[1] !== exp_taken(1, pcf)) $display("FAIL collide_gshare got %h want %h", o_pt[1], exp_taken(1, pcf)); else pass_n++;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 400; n++) begin
            pcf  = pick_pc();
            upc  = pick_pc();
            en   = $urandom_range(0, 3) != 0;
            jmp  = $urandom_range(0, 3) == 0;
            tk   = 1'($urandom_range(0, 1));
            tgt  = 32'h00400000 + 32'($urandom_range(0, 1023)) * 4;
            ptk  = $urandom_range(0, 1) != 0 ? exp_taken(0, upc) : 1'($urandom_range(0, 1));
            ptgt = $urandom_range(0, 1) != 0 ? tgt : exp_target(0, upc);
            ghrm = $urandom_range(0, 3) == 0 ? 6'($urandom) : 6'(m_ghr);
            #1 snap();
            for (int d = 0; d < 2; d++) begin
                total_n++; if (o_pt[d] !== exp_taken(d, pcf)) $display("FAIL rnd_pred dut%0d cyc%0d got %h want %h", d, n, o_pt[d], exp_taken(d, pcf)); else pass_n++;
                total_n++; if (o_tg[d] !== exp_target(d, pcf)) $display("FAIL rnd_target dut%0d cyc%0d got %h want %h", d, n, o_tg[d], exp_target(d, pcf)); else pass_n++;
                total_n++; if (o_gh[d] !== 6'(m_ghr)) $display("FAIL rnd_ghr dut%0d cyc%0d got %h want %h", d, n, o_gh[d], 6'(m_ghr)); else pass_n++;
                total_n++; if (o_mp[d] !== exp_misp()) $display("FAIL rnd_misp dut%0d cyc%0d got %h want %h", d, n, o_mp[d], exp_misp()); else pass_n++;
                if (en) begin
                    total_n++; if (o_rd[d] !== exp_redir()) $display("FAIL rnd_redirect dut%0d cyc%0d got %h want %h", d, n, o_rd[d], exp_redir()); else pass_n++;
                end
                total_n++; if (o_pb[d] !== m_br) $display("FAIL rnd_perf_br dut%0d cyc%0d got %h want %h", d, n, o_pb[d], m_br); else pass_n++;
                total_n++; if (o_pm[d] !== m_mp) $display("FAIL rnd_perf_mp dut%0d cyc%0d got %h want %h", d, n, o_pm[d], m_mp); else pass_n++;
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_midrun();
        drive(1, 1, 32'h00400010, 1, 32'h00400500, 0, 32'h00400014);
        tick();
        idle();
        pcf = 32'h00400010;
        #1 rst_n = 0;
        model_reset();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b0 || o_tg[d] !== 32'h00400014) $display("FAIL midrun_reset_pred dut%0d got %h/%h want 0/00400014", d, o_pt[d], o_tg[d]); else pass_n++;
            total_n++; if (o_gh[d] !== 6'd0 || o_pb[d] !== 32'd0 || o_pm[d] !== 32'd0) $display("FAIL midrun_reset_state dut%0d got %h/%h/%h want 0/0/0", d, o_gh[d], o_pb[d], o_pm[d]); else pass_n++;
        end
        @(negedge clk);
        rst_n = 1;
        drive(1, 1, 32'h00400010, 1, 32'h00400500, 1, 32'h00400500);
        tick();
        idle();
        #1 snap();
        for (int d = 0; d < 2; d++) begin
            total_n++; if (o_pt[d] !== 1'b1 || o_tg[d] !== 32'h00400500) $display("FAIL first_update_pred dut%0d got %h/%h want 1/00400500", d, o_pt[d], o_tg[d]); else pass_n++;
            total_n++; if (o_pb[d] !== 32'd1) $display("FAIL first_update_perf dut%0d got %h want 1", d, o_pb[d]); else pass_n++;
        end
    endtask

    initial begin
        m_ghr = 0;
        idle();
        pcf = 32'h00400000;
        test_reset();
        test_bimodal();
        test_alias();
        test_jump_mispredict();
        test_gshare();
        test_collision();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
